// File: rtl/htd_pkg.sv
// htd_pkg: shared FSM state encoding and default widths for the tagged-frame decoder family.
package htd_pkg;
  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF = 8;
endpackage

// File: rtl/htd_dec_if.sv
// htd_dec_if: tagged-word input and decoded-frame output bundle of htd_dec.
interface htd_dec_if #(
  parameter int DATA_WIDTH = htd_pkg::DATA_WIDTH_DEF,
  parameter int LEN_WIDTH = htd_pkg::LEN_WIDTH_DEF
);
  logic [DATA_WIDTH:0] iv_data;
  logic i_data_wr;
  logic [DATA_WIDTH-1:0] ov_data;
  logic o_data_wr;
  logic o_sop;
  logic o_eop;
  logic [LEN_WIDTH-1:0] ov_frame_len;
  logic o_len_valid;
  logic o_err;
  modport master (
    output iv_data, i_data_wr,
    input ov_data, o_data_wr, o_sop, o_eop, ov_frame_len, o_len_valid, o_err
  );
  modport slave (
    input iv_data, i_data_wr,
    output ov_data, o_data_wr, o_sop, o_eop, ov_frame_len, o_len_valid, o_err
  );
endinterface

// File: rtl/htd_dec_len_cnt.sv
// htd_dec_len_cnt: saturating frame-length counter; nxt is the count including the current word.
module htd_dec_len_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] nxt
);
  logic [W-1:0] cnt, base;
  always_comb begin
    base = clr ? '0 : cnt;
    nxt = (inc && !(&base)) ? base + W'(1) : base;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt <= '0;
    else cnt <= nxt;
  end
endmodule

// File: rtl/htd_dec.sv
// htd_dec: tail-tag frame decoder with sop/eop/length strobes.
// Define HTD_DEC_LEN_CHECK_EN to truncate frames at MAX_LEN words and drop the remainder.
module htd_dec
  import htd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int MAX_LEN = 16
) (
  input logic i_clk,
  input logic i_rst_n,
  htd_dec_if.slave bus
);
  state_t state;
  logic v, tag, emit, start, over, eop;
  logic [LEN_WIDTH-1:0] len;
  assign v = bus.i_data_wr;
  assign tag = bus.iv_data[DATA_WIDTH];
  assign emit = v && state != DROP;
  assign start = v && state == IDLE;
`ifdef HTD_DEC_LEN_CHECK_EN
  assign over = emit && !tag && len == LEN_WIDTH'(MAX_LEN);
`else
  assign over = 1'b0;
`endif
  assign eop = emit && (tag || over);
  // Counter restarts on the first word of a frame, so len already counts the current word.
  htd_dec_len_cnt #(.W(LEN_WIDTH)) u_len_cnt (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .clr(start),
    .inc(emit),
    .nxt(len)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      bus.ov_data <= '0;
      bus.o_data_wr <= 1'b0;
      bus.o_sop <= 1'b0;
      bus.o_eop <= 1'b0;
      bus.ov_frame_len <= '0;
      bus.o_len_valid <= 1'b0;
      bus.o_err <= 1'b0;
    end else begin
      state <= !v ? state : tag ? IDLE : over ? DROP : (state == IDLE) ? BODY : state;
      bus.ov_data <= emit ? bus.iv_data[DATA_WIDTH-1:0] : bus.ov_data;
      bus.o_data_wr <= emit;
      bus.o_sop <= start;
      bus.o_eop <= eop;
      bus.ov_frame_len <= eop ? len : bus.ov_frame_len;
      bus.o_len_valid <= eop;
      bus.o_err <= over;
    end
  end
endmodule
